// File: rtl/axi_lite_mem_slave_if.sv
// AXI4-Lite bus bundle between one master and the axi_lite_mem_slave.
//
// Handshake rule for every channel: a beat transfers on a rising clock edge
// where both valid and ready are 1. A source holds valid and its payload
// stable from the cycle it raises valid until that edge. Ready may rise or
// fall freely while valid is low.
//
// Signals:
//   AW: axi_awvalid, axi_awready, axi_awaddr[31:0], axi_awprot[2:0]
//   W : axi_wvalid, axi_wready, axi_wdata[31:0], axi_wstrb[3:0]
//   B : axi_bvalid, axi_bready, axi_bresp[1:0]
//   AR: axi_arvalid, axi_arready, axi_araddr[31:0], axi_arprot[2:0]
//   R : axi_rvalid, axi_rready, axi_rdata[31:0], axi_rresp[1:0]
interface axi_lite_mem_slave_if;
  logic        axi_awvalid;
  logic        axi_awready;
  logic [31:0] axi_awaddr;
  logic [2:0]  axi_awprot;
  logic        axi_wvalid;
  logic        axi_wready;
  logic [31:0] axi_wdata;
  logic [3:0]  axi_wstrb;
  logic        axi_bvalid;
  logic        axi_bready;
  logic [1:0]  axi_bresp;
  logic        axi_arvalid;
  logic        axi_arready;
  logic [31:0] axi_araddr;
  logic [2:0]  axi_arprot;
  logic        axi_rvalid;
  logic        axi_rready;
  logic [31:0] axi_rdata;
  logic [1:0]  axi_rresp;

  modport master (
    output axi_awvalid, axi_awaddr, axi_awprot,
    output axi_wvalid, axi_wdata, axi_wstrb,
    output axi_bready,
    output axi_arvalid, axi_araddr, axi_arprot,
    output axi_rready,
    input  axi_awready, axi_wready, axi_bvalid, axi_bresp,
    input  axi_arready, axi_rvalid, axi_rdata, axi_rresp
  );

  modport slave (
    input  axi_awvalid, axi_awaddr, axi_awprot,
    input  axi_wvalid, axi_wdata, axi_wstrb,
    input  axi_bready,
    input  axi_arvalid, axi_araddr, axi_arprot,
    input  axi_rready,
    output axi_awready, axi_wready, axi_bvalid, axi_bresp,
    output axi_arready, axi_rvalid, axi_rdata, axi_rresp
  );
endinterface

// File: rtl/axi_lite_mem_slave.sv
// AXI4-Lite slave in front of DEPTH_WORDS x 32-bit storage at BASE_ADDR.
//
// Ports:
//   clk          - single clock, all logic on the rising edge
//   rst_n        - asynchronous active-low reset
//   bus          - AXI4-Lite slave modport (AW, W, B, AR, R channels)
//   dbg_wr_state - current write-channel state (0 idle, 1 address held,
//                  2 data held, 3 response pending)
//
// Handshakes follow the valid/ready rule documented in the interface file.
// The write side accepts AW and W in either order; the first beat waits in a
// holding register until its partner arrives, then the word is written and a
// response is raised one cycle later. The read side is a single-entry
// pipeline: one AR in flight, data registered on the accepting edge.
// Reads sample storage before a same-edge write lands (read-before-write).
// Out-of-range accesses answer DECERR; writes to them change nothing.
module axi_lite_mem_slave #(
  parameter int          DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic               clk,
  input  logic               rst_n,
  axi_lite_mem_slave_if.slave bus,
  output logic [1:0]         dbg_wr_state
);
  localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {
    WR_IDLE    = 2'd0,
    WR_HAVE_AW = 2'd1,
    WR_HAVE_W  = 2'd2,
    WR_RESP    = 2'd3
  } wr_state_t;

  wr_state_t   wr_state;
  logic        live;        // low during reset and for the first edge after it
  logic [31:0] aw_addr_q;
  logic [31:0] w_data_q;
  logic [3:0]  w_strb_q;
  logic [1:0]  bresp_q;
  logic        rvalid_q;
  logic [31:0] rdata_q;
  logic [1:0]  rresp_q;

  logic [31:0] mem [DEPTH_WORDS];

  logic        aw_fire, w_fire, ar_fire;
  logic        wr_commit;
  logic [31:0] wr_addr, wr_data;
  logic [3:0]  wr_strb;

  // Protection bits carry no meaning for this slave.
  logic unused_prot;
  assign unused_prot = ^{bus.axi_awprot, bus.axi_arprot};

  function automatic logic in_range(input logic [31:0] addr);
    return (addr >= BASE_ADDR) && (((addr - BASE_ADDR) >> (IDX_W + 2)) == 32'd0);
  endfunction

  function automatic logic [IDX_W-1:0] word_idx(input logic [31:0] addr);
    return IDX_W'((addr - BASE_ADDR) >> 2);
  endfunction

  // Readies depend only on registered state, never on the master's valids.
  assign bus.axi_awready = live && (wr_state == WR_IDLE || wr_state == WR_HAVE_W);
  assign bus.axi_wready  = live && (wr_state == WR_IDLE || wr_state == WR_HAVE_AW);
  assign bus.axi_bvalid  = (wr_state == WR_RESP);
  assign bus.axi_bresp   = bresp_q;
  assign bus.axi_arready = live && !rvalid_q;
  assign bus.axi_rvalid  = rvalid_q;
  assign bus.axi_rdata   = rdata_q;
  assign bus.axi_rresp   = rresp_q;
  assign dbg_wr_state    = wr_state;

  assign aw_fire = bus.axi_awvalid && bus.axi_awready;
  assign w_fire  = bus.axi_wvalid && bus.axi_wready;
  assign ar_fire = bus.axi_arvalid && bus.axi_arready;

  // Pick the address/data pair for a write completing this edge: whichever
  // half arrived earlier comes from its holding register.
  always_comb begin
    wr_commit = 1'b0;
    wr_addr   = bus.axi_awaddr;
    wr_data   = bus.axi_wdata;
    wr_strb   = bus.axi_wstrb;
    case (wr_state)
      WR_IDLE:    wr_commit = aw_fire && w_fire;
      WR_HAVE_AW: begin
        wr_commit = w_fire;
        wr_addr   = aw_addr_q;
      end
      WR_HAVE_W:  begin
        wr_commit = aw_fire;
        wr_data   = w_data_q;
        wr_strb   = w_strb_q;
      end
      default:    wr_commit = 1'b0;
    endcase
  end

  // Storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (wr_commit && in_range(wr_addr)) begin
      for (int b = 0; b < 4; b++) begin
        if (wr_strb[b]) mem[word_idx(wr_addr)][8*b +: 8] <= wr_data[8*b +: 8];
      end
    end
  end

  // Write channel FSM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_state  <= WR_IDLE;
      live      <= 1'b0;
      aw_addr_q <= '0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
      bresp_q   <= RESP_OKAY;
    end else begin
      live <= 1'b1;
      case (wr_state)
        WR_IDLE: begin
          if (aw_fire && w_fire) begin
            wr_state <= WR_RESP;
          end else if (aw_fire) begin
            aw_addr_q <= bus.axi_awaddr;
            wr_state  <= WR_HAVE_AW;
          end else if (w_fire) begin
            w_data_q <= bus.axi_wdata;
            w_strb_q <= bus.axi_wstrb;
            wr_state <= WR_HAVE_W;
          end
        end
        WR_HAVE_AW: if (w_fire) wr_state <= WR_RESP;
        WR_HAVE_W:  if (aw_fire) wr_state <= WR_RESP;
        WR_RESP:    if (bus.axi_bready) wr_state <= WR_IDLE;
        default:    wr_state <= WR_IDLE;
      endcase
      if (wr_commit) begin
        bresp_q   <= in_range(wr_addr) ? RESP_OKAY : RESP_DECERR;
        aw_addr_q <= '0;
        w_data_q  <= '0;
        w_strb_q  <= '0;
      end
    end
  end

  // Read channel: arready is low while a response waits, so an AR and an
  // R handshake can never share an edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      rresp_q  <= RESP_OKAY;
    end else if (ar_fire) begin
      rvalid_q <= 1'b1;
      if (in_range(bus.axi_araddr)) begin
        rdata_q <= mem[word_idx(bus.axi_araddr)];
        rresp_q <= RESP_OKAY;
      end else begin
        rdata_q <= '0;
        rresp_q <= RESP_DECERR;
      end
    end else if (rvalid_q && bus.axi_rready) begin
      rvalid_q <= 1'b0;
    end
  end
endmodule

// File: tb/tb_axi_lite_mem_slave.sv
// Self-checking bench for axi_lite_mem_slave: a transaction-level model of
// the slave, a per-cycle compare process, a read-data scoreboard, directed
// scenarios with literal expectations and a randomized concurrent phase.
module tb_axi_lite_mem_slave;
  localparam int          DEPTH = 64;
  localparam logic [31:0] BASE  = 32'h0000_0000;

  logic       clk;
  logic       rst_n;
  logic [1:0] dbg_wr_state;

  axi_lite_mem_slave_if bus ();

  axi_lite_mem_slave #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .bus          (bus),
    .dbg_wr_state (dbg_wr_state)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- checking helpers ----------------
  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic timeout_fail(input string name);
    checks++;
    failures++;
    $display("FAIL %s: timed out (t=%0t)", name, $time);
  endtask

  // ---------------- behavioural model ----------------
  logic [31:0] m_mem [DEPTH];
  bit          m_live, m_aw_held, m_w_held, m_bvalid, m_rvalid;
  logic [31:0] m_aw_addr, m_w_data, m_rdata;
  logic [3:0]  m_w_strb;
  logic [1:0]  m_bresp, m_rresp;
  logic [33:0] exp_q[$];   // {rresp, rdata} owed to the master, in order

  function automatic bit hit(input logic [31:0] a);
    if (a < BASE) return 1'b0;
    return ((a - BASE) / 32'd4) < DEPTH;
  endfunction

  function automatic int widx(input logic [31:0] a);
    return int'((a - BASE) / 32'd4);
  endfunction

  function automatic bit e_awready();
    return m_live && !m_aw_held && !m_bvalid;
  endfunction
  function automatic bit e_wready();
    return m_live && !m_w_held && !m_bvalid;
  endfunction
  function automatic bit e_arready();
    return m_live && !m_rvalid;
  endfunction

  task automatic model_reset();
    m_live = 0; m_aw_held = 0; m_w_held = 0; m_bvalid = 0; m_rvalid = 0;
    m_bresp = 2'b00; m_rresp = 2'b00; m_rdata = 32'h0;
    exp_q.delete();
  endtask

  task automatic model_step();
    bit aw_f, w_f, ar_f;
    logic [31:0] a, d;
    logic [3:0]  s;
    aw_f = bus.axi_awvalid && e_awready();
    w_f  = bus.axi_wvalid && e_wready();
    ar_f = bus.axi_arvalid && e_arready();
    // Read side first: a write landing on the same edge is not yet visible.
    if (ar_f) begin
      m_rvalid = 1;
      if (hit(bus.axi_araddr)) begin
        m_rdata = m_mem[widx(bus.axi_araddr)];
        m_rresp = 2'b00;
      end else begin
        m_rdata = 32'h0;
        m_rresp = 2'b11;
      end
      exp_q.push_back({m_rresp, m_rdata});
    end else if (m_rvalid && bus.axi_rready) begin
      m_rvalid = 0;
    end
    if (m_bvalid) begin
      if (bus.axi_bready) m_bvalid = 0;
    end else if ((m_aw_held || aw_f) && (m_w_held || w_f)) begin
      a = m_aw_held ? m_aw_addr : bus.axi_awaddr;
      d = m_w_held ? m_w_data : bus.axi_wdata;
      s = m_w_held ? m_w_strb : bus.axi_wstrb;
      if (hit(a)) begin
        for (int b = 0; b < 4; b++)
          if (s[b]) m_mem[widx(a)][8*b +: 8] = d[8*b +: 8];
      end
      m_bvalid  = 1;
      m_bresp   = hit(a) ? 2'b00 : 2'b11;
      m_aw_held = 0;
      m_w_held  = 0;
    end else begin
      if (aw_f) begin m_aw_held = 1; m_aw_addr = bus.axi_awaddr; end
      if (w_f)  begin m_w_held = 1; m_w_data = bus.axi_wdata; m_w_strb = bus.axi_wstrb; end
    end
    m_live = 1;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else model_step();
    end
  end

  // ---------------- per-cycle compare + scoreboard ----------------
  initial begin
    logic [33:0] e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        check("rst_rdata", bus.axi_rdata, 32'h0);
        check("rst_bresp", bus.axi_bresp, 2'b00);
        check("rst_rresp", bus.axi_rresp, 2'b00);
        check("rst_dbg_state", dbg_wr_state, 2'd0);
      end
      check("awready", bus.axi_awready, e_awready());
      check("wready", bus.axi_wready, e_wready());
      check("arready", bus.axi_arready, e_arready());
      check("bvalid", bus.axi_bvalid, m_bvalid);
      check("rvalid", bus.axi_rvalid, m_rvalid);
      if (m_bvalid) check("bresp", bus.axi_bresp, m_bresp);
      if (m_rvalid) begin
        check("rdata", bus.axi_rdata, m_rdata);
        check("rresp", bus.axi_rresp, m_rresp);
      end
      if (bus.axi_rvalid && bus.axi_rready) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL sb_read: got %0h expected nothing outstanding", {bus.axi_rresp, bus.axi_rdata});
        end else begin
          e = exp_q.pop_front();
          check("sb_read", {bus.axi_rresp, bus.axi_rdata}, e);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  int w_first;      // cycle (from task start) bvalid was first seen
  int r_first;      // cycle (from task start) rvalid was first seen
  bit w_trace[8];   // wready seen during the address/data phase

  // bmode: 0 bready high, 1 random bready, 2 bready low for 5 cycles of bvalid
  task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                          input int aw_dly, input int w_dly, input int bmode, output logic [1:0] resp);
    int t, held;
    bit aw_done, w_done, fa, fw, got;
    t = 0; held = 0; aw_done = 0; w_done = 0; got = 0; resp = 2'bxx; w_first = -1;
    bus.axi_awaddr = addr;
    bus.axi_awprot = 3'($urandom_range(0, 7));
    bus.axi_wdata  = data;
    bus.axi_wstrb  = strb;
    while (!(aw_done && w_done) && t < 100) begin
      bus.axi_awvalid = !aw_done && (t >= aw_dly);
      bus.axi_wvalid  = !w_done && (t >= w_dly);
      bus.axi_bready  = (bmode != 2);
      @(negedge clk);
      if (t < 8) w_trace[t] = bus.axi_wready;
      if (bus.axi_bvalid && w_first < 0) w_first = t;
      fa = bus.axi_awvalid && bus.axi_awready;
      fw = bus.axi_wvalid && bus.axi_wready;
      @(posedge clk); #1;
      aw_done |= fa;
      w_done  |= fw;
      t++;
    end
    bus.axi_awvalid = 1'b0;
    bus.axi_wvalid  = 1'b0;
    while (aw_done && w_done && !got && t < 200) begin
      if (bmode == 1) bus.axi_bready = 1'($urandom_range(0, 1));
      else if (bmode == 2) bus.axi_bready = (held >= 5);
      else bus.axi_bready = 1'b1;
      @(negedge clk);
      if (bus.axi_bvalid && w_first < 0) w_first = t;
      if (bmode == 2 && w_first >= 0 && held < 5) begin
        check("hold_bvalid", bus.axi_bvalid, 1'b1);
        check("hold_awready", bus.axi_awready, 1'b0);
        check("hold_wready", bus.axi_wready, 1'b0);
        held++;
      end
      if (bus.axi_bvalid && bus.axi_bready) begin
        got  = 1;
        resp = bus.axi_bresp;
      end
      @(posedge clk); #1;
      t++;
    end
    bus.axi_bready = 1'b0;
    if (!got) timeout_fail("write_response");
  endtask

  // rmode: 0 rready high, 1 random rready, 2 rready low for 5 cycles of rvalid
  task automatic do_read(input logic [31:0] addr, input int ar_dly, input int rmode,
                         input logic [31:0] hold_data, output logic [31:0] data, output logic [1:0] resp);
    int t, held;
    bit ar_done, fa, got;
    t = 0; held = 0; ar_done = 0; got = 0; data = 'x; resp = 2'bxx; r_first = -1;
    bus.axi_araddr = addr;
    bus.axi_arprot = 3'($urandom_range(0, 7));
    while (!ar_done && t < 100) begin
      bus.axi_arvalid = (t >= ar_dly);
      bus.axi_rready  = (rmode != 2);
      @(negedge clk);
      fa = bus.axi_arvalid && bus.axi_arready;
      @(posedge clk); #1;
      ar_done = fa;
      t++;
    end
    bus.axi_arvalid = 1'b0;
    while (ar_done && !got && t < 200) begin
      if (rmode == 1) bus.axi_rready = 1'($urandom_range(0, 1));
      else if (rmode == 2) bus.axi_rready = (held >= 5);
      else bus.axi_rready = 1'b1;
      @(negedge clk);
      if (bus.axi_rvalid && r_first < 0) r_first = t;
      if (rmode == 2 && r_first >= 0 && held < 5) begin
        check("hold_rvalid", bus.axi_rvalid, 1'b1);
        check("hold_arready", bus.axi_arready, 1'b0);
        check("hold_rdata", bus.axi_rdata, hold_data);
        held++;
      end
      if (bus.axi_rvalid && bus.axi_rready) begin
        got  = 1;
        data = bus.axi_rdata;
        resp = bus.axi_rresp;
      end
      @(posedge clk); #1;
      t++;
    end
    bus.axi_rready = 1'b0;
    if (!got) timeout_fail("read_response");
  endtask

  function automatic logic [31:0] rand_addr();
    case ($urandom_range(0, 9))
      0:       return DEPTH * 4 + $urandom_range(0, 63);
      1:       return 32'hFFFF_FFFC - $urandom_range(0, 15);
      default: return BASE + $urandom_range(0, DEPTH * 4 - 1);
    endcase
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] d;
    logic [1:0]  r, r2;
    rst_n = 1'b0;
    bus.axi_awvalid = 0; bus.axi_awaddr = 0; bus.axi_awprot = 0;
    bus.axi_wvalid  = 0; bus.axi_wdata  = 0; bus.axi_wstrb  = 0;
    bus.axi_bready  = 0;
    bus.axi_arvalid = 0; bus.axi_araddr = 0; bus.axi_arprot = 0;
    bus.axi_rready  = 0;

    // Reset state, then release mid-cycle.
    repeat (3) @(posedge clk);
    #1;
    check("rst_awready", bus.axi_awready, 1'b0);
    check("rst_arready", bus.axi_arready, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);
    check("pre_edge_awready", bus.axi_awready, 1'b0);
    @(posedge clk); #1;
    @(negedge clk);
    check("post_rst_awready", bus.axi_awready, 1'b1);
    check("post_rst_wready", bus.axi_wready, 1'b1);
    check("post_rst_arready", bus.axi_arready, 1'b1);
    @(posedge clk); #1;

    // Reset while an AW waits for its W.
    bus.axi_awaddr  = 32'h40;
    bus.axi_awvalid = 1'b1;
    @(posedge clk); #1;
    bus.axi_awvalid = 1'b0;
    @(negedge clk);
    check("aw_held_awready", bus.axi_awready, 1'b0);
    check("aw_held_wready", bus.axi_wready, 1'b1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("mid_rst_awready", bus.axi_awready, 1'b0);
      check("mid_rst_wready", bus.axi_wready, 1'b0);
      check("mid_rst_arready", bus.axi_arready, 1'b0);
      check("mid_rst_bvalid", bus.axi_bvalid, 1'b0);
      check("mid_rst_rvalid", bus.axi_rvalid, 1'b0);
      @(posedge clk); #1;
    end
    rst_n = 1'b1;
    @(negedge clk);
    check("rel_awready_low", bus.axi_awready, 1'b0);
    @(posedge clk); #1;
    @(negedge clk);
    check("rel_awready", bus.axi_awready, 1'b1);
    check("rel_wready", bus.axi_wready, 1'b1);
    check("rel_arready", bus.axi_arready, 1'b1);
    repeat (4) begin
      check("rel_no_bvalid", bus.axi_bvalid, 1'b0);
      @(posedge clk); #1;
      @(negedge clk);
    end
    @(posedge clk); #1;

    // Fill storage so every later read has a defined value.
    for (int i = 0; i < DEPTH; i++) do_write(BASE + 32'(i * 4), $urandom, 4'hF, 0, 0, 0, r);

    // AW+W same cycle, then read back.
    do_write(32'h10, 32'hDEADBEEF, 4'hF, 0, 0, 0, r);
    check("t1_bresp", r, 2'b00);
    check("t1_b_latency", w_first, 1);
    do_read(32'h10, 0, 0, 32'h0, d, r);
    check("t1_rdata", d, 32'hDEADBEEF);
    check("t1_rresp", r, 2'b00);
    check("t1_r_latency", r_first, 1);

    // W at cycle 0, AW at cycle 3.
    do_write(32'h30, 32'h5A5A0F0F, 4'hF, 3, 0, 0, r);
    check("t2_wready_c0", w_trace[0], 1'b1);
    check("t2_wready_c1", w_trace[1], 1'b0);
    check("t2_wready_c2", w_trace[2], 1'b0);
    check("t2_wready_c3", w_trace[3], 1'b0);
    check("t2_b_first", w_first, 4);
    check("t2_bresp", r, 2'b00);

    // Byte strobes, then an all-zero strobe.
    do_write(32'h20, 32'h11223344, 4'hF, 0, 0, 0, r);
    do_write(32'h20, 32'hAABBCCDD, 4'b0101, 0, 0, 0, r);
    do_read(32'h20, 0, 0, 32'h0, d, r);
    check("t3_strb_rdata", d, 32'h11BB33DD);
    do_write(32'h22, 32'hFFFFFFFF, 4'b0000, 0, 0, 0, r);
    check("t3_strb0_bresp", r, 2'b00);
    do_read(32'h20, 0, 0, 32'h0, d, r);
    check("t3_strb0_rdata", d, 32'h11BB33DD);

    // Range boundary.
    do_write(32'h0, 32'hCAFEF00D, 4'hF, 0, 0, 0, r);
    do_write(BASE + DEPTH * 4, 32'hFFFFFFFF, 4'hF, 1, 0, 0, r);
    check("t4_oor_bresp", r, 2'b11);
    do_read(BASE + DEPTH * 4, 0, 0, 32'h0, d, r);
    check("t4_oor_rdata", d, 32'h0);
    check("t4_oor_rresp", r, 2'b11);
    do_read(32'h0, 0, 0, 32'h0, d, r);
    check("t4_word0_kept", d, 32'hCAFEF00D);
    do_write(BASE + DEPTH * 4 - 4, 32'h13579BDF, 4'hF, 0, 2, 0, r);
    check("t4_last_bresp", r, 2'b00);
    do_read(BASE + DEPTH * 4 - 1, 0, 0, 32'h0, d, r);
    check("t4_last_rdata", d, 32'h13579BDF);

    // Back-pressure on R and B.
    do_read(32'h10, 0, 2, 32'hDEADBEEF, d, r);
    check("t5_rdata", d, 32'hDEADBEEF);
    do_write(32'h44, 32'h0F1E2D3C, 4'hF, 0, 0, 2, r);
    check("t5_bresp", r, 2'b00);

    // Same-edge read and write to one word: read sees the old value.
    do_write(32'h50, 32'h01234567, 4'hF, 0, 0, 0, r);
    fork
      do_write(32'h50, 32'h89ABCDEF, 4'hF, 0, 0, 0, r2);
      do_read(32'h50, 0, 0, 32'h0, d, r);
    join
    check("t6_rbw_old", d, 32'h01234567);
    do_read(32'h50, 0, 0, 32'h0, d, r);
    check("t6_rbw_new", d, 32'h89ABCDEF);

    // Randomized concurrent traffic.
    fork
      begin
        logic [31:0] a;
        logic [1:0]  wr;
        repeat (150) begin
          a = rand_addr();
          do_write(a, $urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 3),
                   $urandom_range(0, 3), 1, wr);
          check("rnd_bresp", wr, hit(a) ? 2'b00 : 2'b11);
        end
      end
      begin
        logic [31:0] rd;
        logic [1:0]  rr;
        repeat (150) do_read(rand_addr(), $urandom_range(0, 2), 1, 32'h0, rd, rr);
      end
    join

    repeat (3) @(posedge clk);
    check("end_sb_empty", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
